serial_mag_comp: RTL
====================

// Module: serial_mag_comp
// PURPOSE
//   Multi-cycle magnitude comparator for WIDTH-bit operands A and B.
//   - Processes one nibble pair per clock, least-significant nibble first.
//   - Carries the running less/equal/greater result forward as the cascade
//     input of the next nibble, in the style of 7485-type cascaded stages.
//   - Sits between the operand source and downstream consumers of the
//     L/E/G flags.
// PARAMETERS
//   WIDTH   16   operand width in bits; must be a multiple of 4 and >= 8.
//   NIB     WIDTH/4 (derived localparam)   number of nibble steps.
// PORTS
//   clk     in   1       single clock; all logic is rising-edge.
//   rst_n   in   1       synchronous, active-low reset.
//   start   in   1       request a compare; accepted only when busy=0.
//   numA    in   WIDTH   operand A; sampled on the accepting edge.
//   numB    in   WIDTH   operand B; sampled on the accepting edge.
//   busy    out  1       high while in state RUN.
//   done    out  1       one-cycle pulse; L/E/G are valid with it.
//   L       out  1       A < B (registered; held until the next result).
//   E       out  1       A == B (registered; held).
//   G       out  1       A > B (registered; held).
// BEHAVIOUR
//   - Reset (rst_n=0 at an edge): state<=IDLE; busy, done, L, E, G all <= 0.
//     Captured operands, the nibble index and the running cascade are cleared.
//   - States:
//     - IDLE: start=1 captures numA/numB, sets idx<=0, running cascade
//       (rl,re,rg)<=(0,1,0), and moves to RUN.
//     - RUN: each edge processes nibble idx:
//       - eh = (a_n==b_n); lh = (a_n<b_n); gh = (a_n>b_n), unsigned
//         4-bit compare.
//       - re <= eh&re; rl <= (eh&rl)|lh; rg <= (eh&rg)|gh.
//       - idx <= idx+1.
//       - On idx==NIB-1: L/E/G <= the same expressions (the final result),
//         then go to DONE.
//     - DONE: done=1 for exactly this cycle; go to IDLE. If start=1 in this
//       cycle, it is accepted as in IDLE and the next state is RUN.
//   - Latency: start accepted at edge t -> done high in the cycle after edge
//     t+NIB. Throughput is one compare per NIB+1 cycles.
//   - L/E/G change only on the edge that enters DONE; they are stable
//     otherwise.
//   - start while busy=1 is ignored. Operand changes after capture have no
//     effect.
//   - Reset mid-RUN aborts the compare: no done pulse, and L/E/G are forced
//     to 0.
//   - Exactly one of L/E/G is 1 after any completed compare without the
//     cascade option.
// CONFIGURATION
//   SERCMP_CASCADE_IN_EN
//   - Defined: adds inputs cas_l, cas_e, cas_g (1 bit each), sampled with
//     the operands on the accepting edge. They seed (rl,re,rg), which allows
//     chaining this block below a lower-order comparator.
//     - Non-one-hot seeds propagate through the same equations, with no
//       correction.
//     - Example: seed (1,1,0) with A==B gives L=1, E=1.
//   - Undefined: no cas_* ports; the seed is fixed at (0,1,0).
// TESTING
//   All tests use WIDTH=16 (NIB=4).
//   1. Reset, then A=16'h1234, B=16'h1234, start one cycle -> busy for 4
//      cycles; done in the 5th cycle after start; L/E/G=0/1/0.
//   2. A=16'h8000, B=16'h7FFF -> G=1, L=0, E=0; only the top nibble decides
//      over the lower results.
//   3. A=16'h0001, B=16'h0002 -> L=1; the LSB nibble decides because all
//      upper nibbles are equal.
//   4. Start A=16'hFFFF, B=16'h0000; pulse start again with A=B=0 one cycle
//     later -> the second start is ignored; result G=1. Then start a new
//     compare and drive rst_n=0 at the 2nd RUN cycle -> busy=0, done never
//     pulses, L/E/G=0.
//   5. Back-to-back: hold start=1 through the DONE cycle with new operands
//      A=16'h0010, B=16'h0100 -> first done pulses, RUN re-entered at once;
//      second done gives L=1.
//   6. With SERCMP_CASCADE_IN_EN: A=B=16'hABCD, cas=(0,0,1) -> G=1, E=0;
//      cas=(0,1,0) -> E=1.

Source files
------------

// File: rtl/serial_mag_comp.sv
// Multi-cycle nibble-serial magnitude comparator, LSB nibble first, 7485-style cascade.
// Optional macro SERCMP_CASCADE_IN_EN adds cas_l/cas_e/cas_g seed inputs.
module serial_mag_comp #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] numA,
   input  logic [WIDTH-1:0] numB,
`ifdef SERCMP_CASCADE_IN_EN
   input  logic             cas_l,
   input  logic             cas_e,
   input  logic             cas_g,
`endif
   output logic             busy,
   output logic             done,
   output logic             L,
   output logic             E,
   output logic             G
);

   localparam int NIB = WIDTH / 4;
   localparam int IW  = $clog2(NIB);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, state_nx;

   logic [WIDTH-1:0] a_q, b_q;
   logic [IW-1:0]    idx;
   logic             rl, re, rg;
   logic [3:0]       a_n, b_n;
   logic             eh, lh, gh;
   logic             nrl, nre, nrg;
   logic             accept, last;
   logic [2:0]       seed;

`ifdef SERCMP_CASCADE_IN_EN
   assign seed = {cas_l, cas_e, cas_g};
`else
   assign seed = 3'b010;
`endif

   assign a_n = 4'(a_q >> {idx, 2'b00});
   assign b_n = 4'(b_q >> {idx, 2'b00});
   assign eh  = (a_n == b_n);
   assign lh  = (a_n <  b_n);
   assign gh  = (a_n >  b_n);
   assign nre = eh & re;
   assign nrl = (eh & rl) | lh;
   assign nrg = (eh & rg) | gh;

   assign last   = (idx == IW'(NIB - 1));
   assign accept = start && (state != RUN);
   assign busy   = (state == RUN);
   assign done   = (state == DONE);

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = RUN;
         RUN:     if (last)  state_nx = DONE;
         DONE:    state_nx = start ? RUN : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_q <= '0;
         b_q <= '0;
         idx <= '0;
         rl  <= 1'b0;
         re  <= 1'b0;
         rg  <= 1'b0;
         L   <= 1'b0;
         E   <= 1'b0;
         G   <= 1'b0;
      end else if (accept) begin
         a_q          <= numA;
         b_q          <= numB;
         idx          <= '0;
         {rl, re, rg} <= seed;
      end else if (state == RUN) begin
         rl  <= nrl;
         re  <= nre;
         rg  <= nrg;
         idx <= idx + 1'b1;
         // result registers move only on the edge entering DONE
         if (last) begin
            L <= nrl;
            E <= nre;
            G <= nrg;
         end
      end
   end

endmodule
